uart_transmitter: RTL and testbench

Serial UART transmitter producing 8N1 frames (start bit, 8 data bits LSB first, stop bit) on a single TX line at a fixed bit period of CLKS_PER_BIT clock cycles. It sits behind the data-memory MMIO path. A store to the UART data register pulses `tx_start` with the byte. The `tx_busy` flag is exposed to software as the UART status register (bit 0).

---
 rtl/uart_tx_if.sv | 12 +
 rtl/uart_transmitter.sv | 136 +++++++++++++
 tb/tb_uart_transmitter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Byte handshake and serial-line bundle for uart_transmitter.
// The master drives requests and the transmitter returns status.
interface uart_tx_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    modport master (output tx_start, output tx_data, input tx, input tx_busy, input tx_done);
    modport slave  (input tx_start, input tx_data, output tx, output tx_busy, output tx_done);
endinterface

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter; every state lasts CLKS_PER_BIT clocks.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
//
// state    | meaning
// S_IDLE   | line high, waiting for tx_start
// S_START  | start bit (low)
// S_DATA   | data bits, LSB first
// S_PARITY | even parity bit (UART_TX_PARITY_EN only)
// S_STOP   | stop bit (high)
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 68
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          last_cycle;

    assign last_cycle = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Outputs are computed one cycle ahead so tx/tx_busy/tx_done come straight from flops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (state_q != S_IDLE) begin
            cnt_d = last_cycle ? RELOAD : (cnt_q - CW'(1));
        end

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (bus.tx_start) begin
                    shreg_d = bus.tx_data;
                    state_d = S_START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = RELOAD;
                    idx_d   = '0;
                end
            end
            S_START: begin
                if (last_cycle) begin
                    state_d = S_DATA;
                    tx_d    = shreg_q[0];
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                if (last_cycle) begin
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = ^shreg_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = shreg_q[idx_q + 3'd1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (last_cycle) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (last_cycle) begin
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.tx      = tx_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_q;
endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter at CLKS_PER_BIT=4.
// Expected line levels come from a frame model: bit k of the frame is held for CPB cycles.
module tb_uart_transmitter;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FLEN = FB * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    uart_tx_if bus ();

    uart_transmitter #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got running sim, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic frame_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_check(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            tick();
            checks++;
            if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b0) begin
                errors++;
                $display("FAIL %s idle cyc %0d: got tx=%b busy=%b done=%b, required tx=1 busy=0 done=0",
                         name, i, bus.tx, bus.tx_busy, bus.tx_done);
            end
        end
    endtask

    task automatic launch(input logic [7:0] d);
        bus.tx_start = 1'b1;
        bus.tx_data  = d;
        tick();
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'($urandom);
    endtask

    // Entered in the first frame cycle; returns in the tx_done cycle (or one cycle later if chaining).
    task automatic check_frame(input logic [7:0] d, input int poke, input bit chain,
                               input logic [7:0] nd, input string name);
        logic [7:0] recon = '0;
        for (int c = 0; c < FLEN; c++) begin
            checks++;
            if (bus.tx !== frame_bit(d, c / CPB) || bus.tx_busy !== 1'b1 || bus.tx_done !== 1'b0) begin
                errors++;
                $display("FAIL %s cyc %0d: got tx=%b busy=%b done=%b, required tx=%b busy=1 done=0",
                         name, c, bus.tx, bus.tx_busy, bus.tx_done, frame_bit(d, c / CPB));
            end
            if ((c % CPB) == CPB / 2 && (c / CPB) >= 1 && (c / CPB) <= 8)
                recon[(c / CPB) - 1] = bus.tx;
            if (c == poke) begin
                bus.tx_start = 1'b1;
                bus.tx_data  = 8'hFF;
            end else begin
                bus.tx_start = 1'b0;
                bus.tx_data  = 8'($urandom);
            end
            tick();
        end
        bus.tx_start = 1'b0;
        checks++;
        if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b1) begin
            errors++;
            $display("FAIL %s end: got tx=%b busy=%b done=%b, required tx=1 busy=0 done=1",
                     name, bus.tx, bus.tx_busy, bus.tx_done);
        end
        checks++;
        if (recon !== d) begin
            errors++;
            $display("FAIL %s byte: got %02h, required %02h", name, recon, d);
        end
        if (chain) launch(nd);
    endtask

    task automatic test_reset();
        bus.tx_start = 1'b1;
        bus.tx_data  = 8'h5A;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b0) begin
                errors++;
                $display("FAIL reset hold cyc %0d: got tx=%b busy=%b done=%b, required 1/0/0",
                         i, bus.tx, bus.tx_busy, bus.tx_done);
            end
        end
        rst = 1'b0;
        bus.tx_start = 1'b0;
        idle_check(8, "reset_release");
    endtask

    task automatic test_single();
        launch(8'h55);
        check_frame(8'h55, -1, 1'b0, 8'h00, "byte55");
        idle_check(2, "byte55");
        launch(8'hA3);
        check_frame(8'hA3, -1, 1'b0, 8'h00, "byteA3");
        idle_check(2, "byteA3");
        launch(8'h07);
        check_frame(8'h07, -1, 1'b0, 8'h00, "byte07");
        idle_check(2, "byte07");
    endtask

    task automatic test_start_while_busy();
        launch(8'h0F);
        check_frame(8'h0F, 9, 1'b0, 8'h00, "busy_ignore");
        idle_check(FLEN + 4, "busy_ignore");
    endtask

    task automatic test_back_to_back();
        launch(8'h3C);
        check_frame(8'h3C, -1, 1'b1, 8'h81, "b2b_first");
        check_frame(8'h81, -1, 1'b0, 8'h00, "b2b_second");
        idle_check(2, "b2b");
    endtask

    task automatic test_mid_reset();
        launch(8'h00);
        for (int c = 0; c < 15; c++) begin
            checks++;
            if (bus.tx !== frame_bit(8'h00, c / CPB) || bus.tx_busy !== 1'b1) begin
                errors++;
                $display("FAIL midrst pre cyc %0d: got tx=%b busy=%b, required tx=%b busy=1",
                         c, bus.tx, bus.tx_busy, frame_bit(8'h00, c / CPB));
            end
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b0) begin
            errors++;
            $display("FAIL midrst abort: got tx=%b busy=%b done=%b, required 1/0/0",
                     bus.tx, bus.tx_busy, bus.tx_done);
        end
        idle_check(FLEN, "midrst_quiet");
        launch(8'hC6);
        check_frame(8'hC6, -1, 1'b0, 8'h00, "midrst_resend");
        idle_check(1, "midrst_resend");
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic [7:0] nd;
        d = 8'($urandom);
        launch(d);
        for (int i = 0; i < 6; i++) begin
            nd = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                check_frame(d, -1, 1'b1, nd, "rand_b2b");
            end else begin
                check_frame(d, int'($urandom_range(0, FLEN - 2)), 1'b0, 8'h00, "rand_gap");
                idle_check(int'($urandom_range(1, 5)), "rand_gap");
                launch(nd);
            end
            d = nd;
        end
        check_frame(d, -1, 1'b0, 8'h00, "rand_last");
        idle_check(2, "rand_last");
    endtask

    initial begin
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'h00;
        test_reset();
        test_single();
        test_start_while_busy();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
